hci_l2_bank_arbiter: RTL and testbench

HCI_L2_BANK_ARBITER -- requirements
Module: hci_l2_bank_arbiter

---
 rtl/hci_l2_bank_arbiter.sv | 147 ++++++++++++++
 tb/tb_hci_l2_bank_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hci_l2_bank_arbiter.sv
// Shares one L2 bank between two priority groups of channels (or one flat round-robin ring),
// with starvation protection for the low-priority group and a fixed-latency response return path.
module hci_l2_bank_arbiter #(
  parameter int N_CH0    = 4,
  parameter int N_CH1    = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int STARVE_W = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             arb_mode_i,
  input  logic [STARVE_W-1:0]              starve_thr_i,
  input  logic [N_CH0+N_CH1-1:0]           ch_req_i,
  input  logic [N_CH0+N_CH1-1:0][AW-1:0]   ch_add_i,
  input  logic [N_CH0+N_CH1-1:0]           ch_wen_i,
  input  logic [N_CH0+N_CH1-1:0][DW-1:0]   ch_data_i,
  input  logic [N_CH0+N_CH1-1:0][DW/8-1:0] ch_be_i,
  output logic [N_CH0+N_CH1-1:0]           ch_gnt_o,
  output logic [N_CH0+N_CH1-1:0]           ch_r_valid_o,
  output logic [N_CH0+N_CH1-1:0][DW-1:0]   ch_r_data_o,
  output logic                             mem_req_o,
  output logic [AW-1:0]                    mem_add_o,
  output logic                             mem_wen_o,
  output logic [DW-1:0]                    mem_data_o,
  output logic [DW/8-1:0]                  mem_be_o,
  input  logic                             mem_gnt_i,
  input  logic [DW-1:0]                    mem_r_data_i
);

  localparam int N   = N_CH0 + N_CH1;
  localparam int IW  = $clog2(N);
  localparam int P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
  localparam int P1W = (N_CH1 > 1) ? $clog2(N_CH1) : 1;

  // Pointer arithmetic never exceeds 2*m-1, so one conditional subtract replaces a modulo.
  function automatic int wrap(input int v, input int m);
    return (v >= m) ? v - m : v;
  endfunction

  logic [P0W-1:0]      ptr0_q, w0;
  logic [P1W-1:0]      ptr1_q, w1;
  logic [IW-1:0]       gptr_q, wg, win;
  logic [STARVE_W-1:0] cnt_q;
  logic [N_CH1-1:0]    g1_req;
  logic                f0, f1, fg;
  logic                g0_any, g1_any, starve, pick_g1, win_g1, any_req, xfer, g1_lose;

  logic [MEM_LAT-1:0]         pv_q, pwen_q;
  logic [MEM_LAT-1:0][IW-1:0] pidx_q;

  assign g1_req  = ch_req_i[N-1:N_CH0];
  assign g0_any  = |ch_req_i[N_CH0-1:0];
  assign g1_any  = |g1_req;
  assign any_req = |ch_req_i;
  assign xfer    = any_req & mem_gnt_i;

  always_comb begin
    w0 = '0;
    f0 = 1'b0;
    for (int i = 0; i < N_CH0; i++) begin
      if (!f0 && ch_req_i[wrap(int'(ptr0_q) + i, N_CH0)]) begin
        f0 = 1'b1;
        w0 = P0W'(wrap(int'(ptr0_q) + i, N_CH0));
      end
    end
    w1 = '0;
    f1 = 1'b0;
    for (int i = 0; i < N_CH1; i++) begin
      if (!f1 && g1_req[wrap(int'(ptr1_q) + i, N_CH1)]) begin
        f1 = 1'b1;
        w1 = P1W'(wrap(int'(ptr1_q) + i, N_CH1));
      end
    end
    wg = '0;
    fg = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!fg && ch_req_i[wrap(int'(gptr_q) + i, N)]) begin
        fg = 1'b1;
        wg = IW'(wrap(int'(gptr_q) + i, N));
      end
    end
  end

  assign starve  = (starve_thr_i != '0) && (cnt_q >= starve_thr_i) && g1_any;
  assign pick_g1 = starve || !g0_any;
  assign win     = arb_mode_i ? wg : (pick_g1 ? IW'(N_CH0) + IW'(w1) : IW'(w0));
  assign win_g1  = (int'(win) >= N_CH0);
  assign g1_lose = !arb_mode_i && g1_any && !(xfer && win_g1);

  assign mem_req_o  = any_req;
  assign mem_add_o  = ch_add_i[win];
  assign mem_wen_o  = ch_wen_i[win];
  assign mem_data_o = ch_data_i[win];
  assign mem_be_o   = ch_be_i[win];

  always_comb begin
    ch_gnt_o = '0;
    if (any_req) ch_gnt_o[win] = mem_gnt_i;
  end

  // Only the pointer of the arbiter that actually produced the winner moves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr0_q <= '0;
      ptr1_q <= '0;
      gptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (xfer) begin
        if (arb_mode_i)  gptr_q <= IW'(wrap(int'(win) + 1, N));
        else if (win_g1) ptr1_q <= P1W'(wrap(int'(w1) + 1, N_CH1));
        else             ptr0_q <= P0W'(wrap(int'(w0) + 1, N_CH0));
      end
      if (xfer && win_g1)               cnt_q <= '0;
      else if (g1_lose && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q   <= '0;
      pwen_q <= '0;
      pidx_q <= '0;
    end else begin
      pv_q[0]   <= xfer;
      pwen_q[0] <= mem_wen_o;
      pidx_q[0] <= win;
      for (int k = 1; k < MEM_LAT; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pwen_q[k] <= pwen_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end
    end
  end

  always_comb begin
    ch_r_valid_o = '0;
    ch_r_data_o  = '0;
    if (pv_q[MEM_LAT-1]) begin
      ch_r_valid_o[pidx_q[MEM_LAT-1]] = 1'b1;
      ch_r_data_o[pidx_q[MEM_LAT-1]]  = pwen_q[MEM_LAT-1] ? mem_r_data_i : '0;
    end
  end

endmodule

// File: tb/tb_hci_l2_bank_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed grants/responses, a negedge monitor pops and compares.
module tb_hci_l2_bank_arbiter;
  localparam int N = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 3;
  localparam logic [DW-1:0] RD = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arb_mode, mem_gnt, mem_req, mem_wen, mem_req4, mem_wen4;
  logic [7:0] thr;
  logic [N-1:0] req, wen, gnt, rvld, gnt4, rvld4;
  logic [N-1:0][AW-1:0] add;
  logic [N-1:0][DW-1:0] wdata, rdata, rdata4;
  logic [N-1:0][DW/8-1:0] be;
  logic [AW-1:0] mem_add, mem_add4;
  logic [DW-1:0] mem_wdata, mem_wdata4, mem_rdata;
  logic [DW/8-1:0] mem_be, mem_be4;

  hci_l2_bank_arbiter #(.N_CH0(4), .N_CH1(2), .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .arb_mode_i(arb_mode), .starve_thr_i(thr),
    .ch_req_i(req), .ch_add_i(add), .ch_wen_i(wen), .ch_data_i(wdata), .ch_be_i(be),
    .ch_gnt_o(gnt), .ch_r_valid_o(rvld), .ch_r_data_o(rdata),
    .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_wen_o(mem_wen), .mem_data_o(mem_wdata),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_r_data_i(mem_rdata));

  hci_l2_bank_arbiter #(.N_CH0(4), .N_CH1(2), .AW(AW), .DW(DW), .MEM_LAT(4), .STARVE_W(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .arb_mode_i(arb_mode), .starve_thr_i(thr),
    .ch_req_i(req), .ch_add_i(add), .ch_wen_i(wen), .ch_data_i(wdata), .ch_be_i(be),
    .ch_gnt_o(gnt4), .ch_r_valid_o(rvld4), .ch_r_data_o(rdata4),
    .mem_req_o(mem_req4), .mem_add_o(mem_add4), .mem_wen_o(mem_wen4), .mem_data_o(mem_wdata4),
    .mem_be_o(mem_be4), .mem_gnt_i(mem_gnt), .mem_r_data_i(mem_rdata));

  typedef struct {logic [N-1:0] gnt; int ch;} gexp_t;
  typedef struct {logic [N-1:0] vld; logic [N-1:0][DW-1:0] dat; int due;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int r4_seen = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic fail_msg(input string name, input string got, input string want);
    failures++;
    $display("FAIL %s got=%s want=%s (cycle %0d)", name, got, want, cyc_n);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        checks++;
        if (gq.size() == 0) fail_msg("gnt_unexpected", $sformatf("%b", gnt), "no request");
        else begin
          gexp_t e;
          e = gq.pop_front();
          if (gnt !== e.gnt) fail_msg("gnt", $sformatf("%b", gnt), $sformatf("%b", e.gnt));
          if (e.ch >= 0) begin
            checks++;
            if (mem_add !== add[e.ch]) fail_msg("mem_add", $sformatf("%h", mem_add), $sformatf("%h", add[e.ch]));
          end
        end
      end
      if (|rvld) begin
        checks++;
        if (rq.size() == 0) fail_msg("rsp_unexpected", $sformatf("%b", rvld), "none");
        else begin
          rexp_t r;
          r = rq.pop_front();
          if (rvld !== r.vld || rdata !== r.dat || cyc_n != r.due)
            fail_msg("rsp", $sformatf("vld=%b dat=%h cyc=%0d", rvld, rdata, cyc_n),
                     $sformatf("vld=%b dat=%h cyc=%0d", r.vld, r.dat, r.due));
        end
      end
      if (|rvld4) r4_seen++;
    end
  end

  task automatic cyc(input logic m, input logic [7:0] t, input logic [N-1:0] r, input logic [N-1:0] w,
                     input logic g, input int ch, input bit push_rsp);
    gexp_t e;
    rexp_t x;
    @(posedge clk);
    #1;
    arb_mode = m; thr = t; req = r; wen = w; mem_gnt = g;
    if (r != '0) begin
      e.ch  = (g && ch >= 0) ? ch : -1;
      e.gnt = (g && ch >= 0) ? (N'(1) << ch) : '0;
      gq.push_back(e);
    end
    if (g && ch >= 0 && push_rsp) begin
      x.vld = N'(1) << ch;
      x.dat = '0;
      x.dat[ch] = w[ch] ? RD : '0;
      x.due = cyc_n + LAT;
      rq.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, '0, '0, 1'b1, -1, 1'b0);
  endtask

  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_b[8] = '{0, 0, 0, 4, 0, 0, 0, 4};
  int seq_d[5] = '{0, 2, 4, 5, 0};
  int seq_e[3] = '{1, 2, 1};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arb_mode = 1'b0; thr = '0; req = '0; wen = '0; mem_gnt = 1'b0; mem_rdata = RD;
    for (int i = 0; i < N; i++) begin
      add[i] = 32'h100 + i; wdata[i] = 32'hD000 + i; be[i] = '1;
    end
    repeat (2) @(negedge clk);
    checks++; if (rvld !== '0 || rvld4 !== '0) fail_msg("reset_rvalid", $sformatf("%b", rvld), "0");
    checks++; if (rdata !== '0) fail_msg("reset_rdata", $sformatf("%h", rdata), "0");
    checks++; if (mem_req !== 1'b0 || gnt !== '0) fail_msg("reset_idle", $sformatf("%b %b", mem_req, gnt), "0 0");
    @(posedge clk); #1 rst = 1'b0;

    // Group 0 round robin, writes
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'd0, 6'b001111, '0, 1'b1, seq_a[k], 1'b1);
    // Starvation threshold 3: channel 4 every 4th cycle, reads
    for (int k = 0; k < 8; k++) cyc(1'b0, 8'd3, 6'b010001, '1, 1'b1, seq_b[k], 1'b1);
    // Threshold 0: channel 4 never wins
    for (int k = 0; k < 6; k++) cyc(1'b0, 8'd0, 6'b010001, '1, 1'b1, 0, 1'b1);
    // Flat round robin
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'd0, 6'b110101, 6'b100100, 1'b1, seq_d[k], 1'b1);
    // No grant for 5 cycles, then pointer of group 0 must still start at 1
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'd0, 6'b100110, '0, 1'b0, -1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'd0, 6'b100110, 6'b000110, 1'b1, seq_e[k], 1'b1);
    idle(6);
    // Single read, response exactly LAT cycles later
    cyc(1'b0, 8'd0, 6'b000100, 6'b000100, 1'b1, 2, 1'b1);
    idle(8);
    // Reset one cycle after a read grant discards it
    r4_seen = 0;
    cyc(1'b0, 8'd0, 6'b000010, 6'b000010, 1'b1, 1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks++; if (rvld !== '0 || rvld4 !== '0 || rdata !== '0 || rdata4 !== '0)
      fail_msg("midreset_outputs", $sformatf("%b %b", rvld, rvld4), "0 0");
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (r4_seen != 0) fail_msg("stale_rvalid_lat4", $sformatf("%0d", r4_seen), "0");
    // Pointers cleared by reset: group 0 starts at channel 0 again
    cyc(1'b0, 8'd0, 6'b001111, '0, 1'b1, 0, 1'b1);
    idle(8);
    checks++; if (gq.size() != 0) fail_msg("gnt_queue_drained", $sformatf("%0d", gq.size()), "0");
    checks++; if (rq.size() != 0) fail_msg("rsp_queue_drained", $sformatf("%0d", rq.size()), "0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
